// File: rtl/ram_dp_async_read_pkg.sv
// ---------------------------------------------------------------------------
// Module  : ram_dp_async_read_pkg
// Desc    : Shared helpers for the async-read register-file RAM.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ram_dp_async_read_pkg;

   localparam int c_WIDTH_DEFAULT = 8;
   localparam int c_DEPTH_DEFAULT = 64;

   // True when an address selects a physical word; only matters for non-power-of-two depths.
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return (addr < depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dp_async_read.sv
// ---------------------------------------------------------------------------
// Module  : ram_dp_async_read
// Desc    : Flip-flop register file, one synchronous write port and one
//           combinational read port, fully cleared by asynchronous reset.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram_dp_async_read
   import ram_dp_async_read_pkg::*;
#(
   parameter  int WIDTH     = c_WIDTH_DEFAULT,
   parameter  int DEPTH     = c_DEPTH_DEFAULT,
   localparam int DEPTH_LOG = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we_n,
   input  logic [DEPTH_LOG-1:0] addr_wr,
   input  logic [DEPTH_LOG-1:0] addr_rd,
   input  logic [WIDTH-1:0]     data_wr,
   output logic [WIDTH-1:0]     data_rd
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_ok;
   logic             w_rd_ok;

   assign w_wr_ok = addr_in_range(32'(addr_wr), DEPTH);
   assign w_rd_ok = addr_in_range(32'(addr_rd), DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (!we_n && w_wr_ok) begin
         r_mem[addr_wr] <= data_wr;
      end
   end

   // No write-through: a same-address write shows up only after the edge.
   assign data_rd = w_rd_ok ? r_mem[addr_rd] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_async_read.sv
// ---------------------------------------------------------------------------
// Module  : tb_ram_dp_async_read
// Desc    : Randomized self-checking bench with an array reference model.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ram_dp_async_read;

   localparam int WIDTH = 8;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             we_n;
   logic [AW-1:0]    addr_wr;
   logic [AW-1:0]    addr_rd;
   logic [WIDTH-1:0] data_wr;
   logic [WIDTH-1:0] data_rd;

   logic [WIDTH-1:0] model [DEPTH];
   int               n_checks = 0;
   int               n_pass   = 0;

   ram_dp_async_read #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_n    (we_n),
      .addr_wr (addr_wr),
      .addr_rd (addr_rd),
      .data_wr (data_wr),
      .data_rd (data_rd)
   );

   always #50 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge clk);
      we_n = 1'b0; addr_wr = a; data_wr = d;
      @(negedge clk);
      we_n = 1'b1;
      if (rst_n) model[a] = d;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a);
      addr_rd = a;
      #1;
      check_eq(tag, data_rd, model[a]);
   endtask

   initial begin
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;

      rst_n = 1'b0; we_n = 1'b1; addr_wr = '0; addr_rd = '0; data_wr = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      // Reset sweep, with a write attempt that must be lost.
      repeat (2) @(negedge clk);
      we_n = 1'b0; addr_wr = 6'd9; data_wr = 8'hEE;
      @(negedge clk);
      we_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         addr_rd = AW'(i); #1;
         check_eq("reset_sweep", data_rd, 8'h00);
      end
      rst_n = 1'b1;
      addr_wr = 6'd9; data_wr = 8'hCC;
      @(negedge clk);
      read_check("idle_edge", 6'd9);

      // Sequential write/readback.
      for (int i = 0; i < DEPTH; i++) begin
         do_write(AW'(i), WIDTH'($urandom));
         read_check("seq_wr", AW'(i));
      end

      // Random-address patterned writes.
      for (int k = 0; k < 64; k++) begin
         a = AW'($urandom_range(0, DEPTH - 1));
         d = WIDTH'((int'(a) << 4) | ((a[0]) ? 'hA : 'h5));
         do_write(a, d);
         read_check("rand_pat", a);
         check_eq("rand_pat_val", data_rd, d);
      end

      // Mixed random enable/address traffic against the model.
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         we_n    = $urandom_range(0, 1) == 0;
         addr_wr = AW'($urandom);
         data_wr = WIDTH'($urandom);
         addr_rd = AW'($urandom);
         #1;
         check_eq("mix_pre", data_rd, model[addr_rd]);
         @(posedge clk);
         #1;
         if (!we_n) model[addr_wr] = data_wr;
         check_eq("mix_post", data_rd, model[addr_rd]);
      end
      @(negedge clk); we_n = 1'b1;

      // Same-address collision: old word before edge, new word after.
      do_write(6'd7, 8'h11);
      @(negedge clk);
      addr_rd = 6'd7; addr_wr = 6'd7; data_wr = 8'h22; we_n = 1'b0;
      #1;
      check_eq("collide_pre", data_rd, 8'h11);
      @(posedge clk); #1;
      check_eq("collide_post", data_rd, 8'h22);
      model[7] = 8'h22;
      @(negedge clk); we_n = 1'b1;

      // Write-disable holds contents.
      addr_wr = 6'd5; data_wr = 8'hFF; we_n = 1'b1;
      repeat (4) @(negedge clk);
      read_check("wr_disable", 6'd5);

      // Mid-run reset clears immediately and swallows writes.
      for (int i = 0; i < 4; i++) do_write(AW'(i), 8'hA5);
      read_check("pre_rst", 6'd2);
      #10;
      rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < 4; i++) read_check("mid_rst", AW'(i));
      we_n = 1'b0; addr_wr = 6'd2; data_wr = 8'h77;
      @(negedge clk);
      we_n = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) read_check("post_rst", AW'(i));

      // First write after release lands.
      do_write(6'd63, 8'h3C);
      read_check("first_after_rst", 6'd63);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
